// File: rtl/alu_sequencer_pkg.sv
// alu_sequencer_pkg: ALU function codes, MUL opcode and FSM state encoding.
// The MULT state is only present when ALU_MUL_EN is defined.
package alu_sequencer_pkg;
  localparam logic [3:0] F_ADD = 4'b0010;
  localparam logic [3:0] F_SUB = 4'b0110;
  localparam logic [3:0] F_AND = 4'b0000;
  localparam logic [3:0] F_ORR = 4'b0001;
  localparam logic [3:0] F_PASSB = 4'b0111;
  localparam logic [3:0] F_MUL = 4'b1000;
  localparam logic [3:0] F_ILLEGAL = 4'b1111;
  localparam logic [10:0] MUL_OP = 11'b10011011000;
`ifdef ALU_MUL_EN
  typedef enum logic [1:0] {IDLE, HOLD, MULT} state_t;
`else
  typedef enum logic [1:0] {IDLE, HOLD} state_t;
`endif
endpackage

// File: rtl/alu_func_decode.sv
// alu_func_decode: combinational ALUOp/opcode to ALU function decode.
// MUL recognition is compiled in only with ALU_MUL_EN.
module alu_func_decode
  import alu_sequencer_pkg::*;
#(
  parameter int OP_W = 11
) (
  input  logic [OP_W-1:0] Operation,
  input  logic [1:0]      ALUOperation,
  output logic [3:0]      func,
  output logic            illegal,
  output logic            mul
);
  logic [2:0] key;
  assign key = {Operation[9], Operation[8], Operation[3]};
`ifdef ALU_MUL_EN
  assign mul = ALUOperation == 2'b10 && Operation == OP_W'(MUL_OP);
`else
  logic unused_op;
  assign unused_op = ^Operation;
  assign mul = 1'b0;
`endif
  always_comb begin
    func = F_ILLEGAL;
    illegal = 1'b0;
    if (ALUOperation == 2'b00) func = F_ADD;
    else if (ALUOperation[0]) func = F_PASSB;
    else if (mul) func = F_MUL;
    else if (key == 3'b001) func = F_ADD;
    else if (key == 3'b101) func = F_SUB;
    else if (key == 3'b000) func = F_AND;
    else if (key == 3'b010) func = F_ORR;
    else illegal = 1'b1;
  end
endmodule

// File: rtl/alu_sequencer.sv
// alu_sequencer: handshaked ALU control sequencer with registered function output.
// Define ALU_MUL_EN to add the multi-cycle MUL path (MULT state, counter, busy).
module alu_sequencer
  import alu_sequencer_pkg::*;
#(
  parameter int OP_W = 11,
  parameter int FUNC_W = 4,
  parameter int MUL_CYCLES = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [OP_W-1:0]   Operation,
  input  logic [1:0]        ALUOperation,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [FUNC_W-1:0] ALUFunc,
  output logic              illegal,
  output logic              busy
);
  if (FUNC_W < 4 || MUL_CYCLES < 2 || MUL_CYCLES > 15) begin : g_bad_cfg
    $error("alu_sequencer: FUNC_W must be >= 4 and MUL_CYCLES in 2..15");
  end
  state_t state, state_nx;
  logic [3:0] dec_func;
  logic dec_illegal, dec_mul, accept;
  logic [FUNC_W-1:0] func_q;
  logic illegal_q;
  alu_func_decode #(.OP_W(OP_W)) u_dec (
    .Operation(Operation),
    .ALUOperation(ALUOperation),
    .func(dec_func),
    .illegal(dec_illegal),
    .mul(dec_mul)
  );
  assign in_ready = state == IDLE || (state == HOLD && out_ready);
  assign accept = in_valid && in_ready;
  assign out_valid = state == HOLD;
  assign ALUFunc = func_q;
  assign illegal = illegal_q;
`ifdef ALU_MUL_EN
  logic [3:0] cnt;
  assign busy = state == MULT;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else cnt <= (accept && dec_mul) ? 4'(MUL_CYCLES - 1) : (state == MULT && cnt != 0) ? cnt - 4'd1 : cnt;
`else
  assign busy = 1'b0;
`endif
  always_comb begin
    state_nx = state;
    if (accept) state_nx = HOLD;
    else if (state == HOLD && out_ready) state_nx = IDLE;
`ifdef ALU_MUL_EN
    if (accept && dec_mul) state_nx = MULT;
    else if (state == MULT && cnt == 0) state_nx = HOLD;
`endif
  end
  // MUL results are loaded when the counter expires, not at accept time
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      func_q <= '0;
      illegal_q <= 1'b0;
    end else begin
      state <= state_nx;
      if (accept && !dec_mul) begin
        func_q <= FUNC_W'(dec_func);
        illegal_q <= dec_illegal;
      end
`ifdef ALU_MUL_EN
      else if (state == MULT && cnt == 0) begin
        func_q <= FUNC_W'(F_MUL);
        illegal_q <= 1'b0;
      end
`endif
    end
endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer: scoreboard bench for alu_sequencer (default and ALU_MUL_EN builds).
module tb_alu_sequencer;
  localparam int MUL_CYCLES = 4;
  localparam logic [10:0] MULOP = 11'b10011011000;
  logic clk = 1'b0;
  logic rst_n, in_valid, in_ready, out_valid, out_ready, illegal, busy;
  logic [10:0] Operation;
  logic [1:0] ALUOperation;
  logic [3:0] ALUFunc;
  logic [4:0] q[$];
  logic [5:0] e;
  int n_vec = 0, n_err = 0;

  alu_sequencer #(.OP_W(11), .FUNC_W(4), .MUL_CYCLES(MUL_CYCLES)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .Operation(Operation), .ALUOperation(ALUOperation), .out_valid(out_valid),
    .out_ready(out_ready), .ALUFunc(ALUFunc), .illegal(illegal), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic ref_mul(logic [1:0] a, logic [10:0] o);
`ifdef ALU_MUL_EN
    return a == 2'b10 && o == MULOP;
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [4:0] ref_dec(logic [1:0] a, logic [10:0] o);
    if (a == 2'b00) return 5'b00010;
    if (a[0]) return 5'b00111;
    if (ref_mul(a, o)) return 5'b01000;
    case ({o[9], o[8], o[3]})
      3'b001: return 5'b00010;
      3'b101: return 5'b00110;
      3'b000: return 5'b00000;
      3'b010: return 5'b00001;
      default: return 5'b11111;
    endcase
  endfunction

  task automatic test_reset;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; Operation = '0; ALUOperation = '0;
    #3;
    n_vec++;
    if ({out_valid, busy, illegal, ALUFunc} !== 7'b0) begin
      n_err++; $display("FAIL reset_outputs: got %b want 0000000", {out_valid, busy, illegal, ALUFunc});
    end
    tick; tick;
    rst_n = 1'b1;
    #1;
    n_vec++;
    if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
  endtask

  task automatic test_sub;
    out_ready = 1'b1; in_valid = 1'b1; ALUOperation = 2'b10; Operation = 11'b11001011000;
    q.push_back(5'b00110);
    tick;
    in_valid = 1'b0; Operation = '1; ALUOperation = 2'b11;
    #1;
    e = {1'b1, q.pop_front()}; n_vec++;
    if ({out_valid, illegal, ALUFunc} !== e) begin
      n_err++; $display("FAIL sub_result: got %b want %b", {out_valid, illegal, ALUFunc}, e);
    end
    tick;
    n_vec++;
    if ({out_valid, illegal, ALUFunc} !== 6'b000110) begin
      n_err++; $display("FAIL sub_retire_hold: got %b want 000110", {out_valid, illegal, ALUFunc});
    end
  endtask

  task automatic test_illegal_passb;
    out_ready = 1'b1; in_valid = 1'b1; ALUOperation = 2'b10; Operation = 11'b00100001000;
    q.push_back(5'b11111);
    tick;
    ALUOperation = 2'b11; Operation = 11'b01010101010;
    q.push_back(5'b00111);
    #1;
    n_vec++;
    if (in_ready !== 1'b1) begin n_err++; $display("FAIL ill_in_ready: got %b want 1", in_ready); end
    e = {1'b1, q.pop_front()}; n_vec++;
    if ({out_valid, illegal, ALUFunc} !== e) begin
      n_err++; $display("FAIL illegal_result: got %b want %b", {out_valid, illegal, ALUFunc}, e);
    end
    tick;
    in_valid = 1'b0;
    e = {1'b1, q.pop_front()}; n_vec++;
    if ({out_valid, illegal, ALUFunc} !== e) begin
      n_err++; $display("FAIL passb_result: got %b want %b", {out_valid, illegal, ALUFunc}, e);
    end
    tick;
    n_vec++;
    if (out_valid !== 1'b0) begin n_err++; $display("FAIL passb_idle: got %b want 0", out_valid); end
  endtask

  task automatic test_hold;
    out_ready = 1'b0; in_valid = 1'b1; ALUOperation = 2'b10; Operation = 11'b0;
    q.push_back(5'b00000);
    tick;
    Operation = 11'b00100000000;
    q.push_back(5'b00001);
    for (int i = 0; i < 3; i++) begin
      #1;
      n_vec++;
      if ({out_valid, in_ready, illegal, ALUFunc} !== 7'b1000000) begin
        n_err++; $display("FAIL hold_%0d: got %b want 1000000", i, {out_valid, in_ready, illegal, ALUFunc});
      end
      tick;
    end
    out_ready = 1'b1;
    #1;
    e = {1'b1, q.pop_front()}; n_vec++;
    if ({out_valid, illegal, ALUFunc} !== e || in_ready !== 1'b1) begin
      n_err++; $display("FAIL hold_and: got %b rdy %b want %b rdy 1", {out_valid, illegal, ALUFunc}, in_ready, e);
    end
    tick;
    ALUOperation = 2'b00; Operation = 11'b11111111111;
    q.push_back(5'b00010);
    e = {1'b1, q.pop_front()}; n_vec++;
    if ({out_valid, illegal, ALUFunc} !== e) begin
      n_err++; $display("FAIL b2b_orr: got %b want %b", {out_valid, illegal, ALUFunc}, e);
    end
    tick;
    in_valid = 1'b0;
    e = {1'b1, q.pop_front()}; n_vec++;
    if ({out_valid, illegal, ALUFunc} !== e) begin
      n_err++; $display("FAIL b2b_add: got %b want %b", {out_valid, illegal, ALUFunc}, e);
    end
    tick;
    n_vec++;
    if (out_valid !== 1'b0) begin n_err++; $display("FAIL b2b_idle: got %b want 0", out_valid); end
  endtask

  task automatic test_mul;
    out_ready = 1'b1; in_valid = 1'b1; ALUOperation = 2'b10; Operation = MULOP;
`ifdef ALU_MUL_EN
    q.push_back(5'b01000);
`else
    q.push_back(5'b00010);
`endif
    tick;
    in_valid = 1'b0;
`ifdef ALU_MUL_EN
    for (int i = 0; i < MUL_CYCLES; i++) begin
      n_vec++;
      if ({busy, in_ready, out_valid} !== 3'b100) begin
        n_err++; $display("FAIL mul_busy_%0d: got %b want 100", i, {busy, in_ready, out_valid});
      end
      tick;
    end
`endif
    e = {1'b1, q.pop_front()}; n_vec++;
    if ({out_valid, busy, illegal, ALUFunc} !== {e[5], 1'b0, e[4:0]}) begin
      n_err++; $display("FAIL mul_result: got %b want %b", {out_valid, busy, illegal, ALUFunc}, {e[5], 1'b0, e[4:0]});
    end
    tick;
    n_vec++;
    if (out_valid !== 1'b0) begin n_err++; $display("FAIL mul_idle: got %b want 0", out_valid); end
  endtask

  task automatic test_mul_reset;
    logic seen = 1'b0;
    out_ready = 1'b0; in_valid = 1'b1; ALUOperation = 2'b10; Operation = MULOP;
    tick;
    in_valid = 1'b0;
    tick; tick;
    rst_n = 1'b0;
    #1;
    n_vec++;
    if ({out_valid, busy, illegal, ALUFunc} !== 7'b0) begin
      n_err++; $display("FAIL mulrst_now: got %b want 0000000", {out_valid, busy, illegal, ALUFunc});
    end
    tick; tick;
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick;
      if (out_valid !== 1'b0) seen = 1'b1;
    end
    n_vec++;
    if (seen !== 1'b0) begin n_err++; $display("FAIL mulrst_pulse: got %b want 0", seen); end
  endtask

  task automatic test_back_to_back;
    int ms = 0, mc = 0;
    logic rdy, acc, m;
    q.delete();
    for (int i = 0; i < 300; i++) begin
      in_valid = $urandom_range(0, 3) != 0;
      out_ready = $urandom_range(0, 3) != 0;
      ALUOperation = 2'($urandom);
      Operation = ($urandom_range(0, 4) == 0) ? MULOP : 11'($urandom);
      #1;
      rdy = ms == 0 || (ms == 1 && out_ready);
      n_vec++;
      if ({in_ready, out_valid, busy} !== {rdy, ms == 1, ms == 2}) begin
        n_err++; $display("FAIL rnd_ctl_%0d: got %b want %b", i, {in_ready, out_valid, busy}, {rdy, ms == 1, ms == 2});
      end
      if (ms == 1 && out_ready && q.size() > 0) begin
        e = {1'b1, q.pop_front()}; n_vec++;
        if ({out_valid, illegal, ALUFunc} !== e) begin
          n_err++; $display("FAIL rnd_res_%0d: got %b want %b", i, {out_valid, illegal, ALUFunc}, e);
        end
      end
      acc = in_valid && rdy;
      m = ref_mul(ALUOperation, Operation);
      if (acc) q.push_back(ref_dec(ALUOperation, Operation));
      tick;
      if (acc) begin ms = m ? 2 : 1; mc = MUL_CYCLES - 1; end
      else if (ms == 1 && out_ready) ms = 0;
      else if (ms == 2) begin
        if (mc == 0) ms = 1;
        else mc--;
      end
    end
    in_valid = 1'b0;
  endtask

  initial begin
    test_reset;
    test_sub;
    test_illegal_passb;
    test_hold;
    test_mul;
    test_mul_reset;
    test_back_to_back;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
